// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared widths, limits and the time-record type for the
// lap stopwatch.
//   MINS_W/SECS_W/DECS_W : field widths of a time record
//   SEC_MAX/DEC_MAX      : last value of the seconds and centiseconds fields
//   time_t               : packed {mins, secs, decs}
//   time_is_last()       : true when a record sits at max_mins:59:99
//   time_next()          : one-centisecond advance with carry and wrap
package stopwatch_pkg;

  localparam int MINS_W = 7;
  localparam int SECS_W = 6;
  localparam int DECS_W = 7;

  localparam logic [SECS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [DECS_W-1:0] DEC_MAX = 7'd99;

  typedef struct packed {
    logic [MINS_W-1:0] mins;
    logic [SECS_W-1:0] secs;
    logic [DECS_W-1:0] decs;
  } time_t;

  function automatic logic time_is_last(input time_t t, input logic [MINS_W-1:0] max_mins);
    return (t.mins == max_mins) && (t.secs == SEC_MAX) && (t.decs == DEC_MAX);
  endfunction

  // The top of the range wraps to all-zero rather than carrying into mins.
  function automatic time_t time_next(input time_t t, input logic [MINS_W-1:0] max_mins);
    time_t n;
    n = t;
    if (time_is_last(t, max_mins)) begin
      n = '0;
    end else if (t.decs != DEC_MAX) begin
      n.decs = t.decs + 7'd1;
    end else begin
      n.decs = 7'd0;
      if (t.secs != SEC_MAX) begin
        n.secs = t.secs + 6'd1;
      end else begin
        n.secs = 6'd0;
        n.mins = t.mins + 7'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// lap_fifo -- synchronous FIFO of time records used as the lap buffer.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (empties the buffer)
//   push_i  : write data_i (ignored when full unless popping in the same cycle)
//   pop_i   : drop the head (ignored when empty)
//   data_i  : record to write
//   head_o  : oldest record, all-zero while empty
//   count_o : number of stored records
//   full_o  : count_o == DEPTH
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  time_t                        data_i,
  output time_t                        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  time_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // A pop frees the head slot, so a push is accepted when full if a pop
  // happens in the same cycle; with wr == rd it overwrites the departing head.
  always_comb begin
    do_pop_s  = pop_i && (cnt_q != '0);
    do_push_s = push_i && (!full_q || do_pop_s);
    wr_d      = do_push_s ? ptr_inc(wr_q) : wr_q;
    rd_d      = do_pop_s ? ptr_inc(rd_q) : rd_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Storage carries no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
  assign full_o  = full_q;

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch -- minutes:seconds:centiseconds stopwatch with display hold
// and an optional lap buffer (built only when STOPWATCH_LAP_EN is defined).
//   CLK          : clock, rising edge
//   reset        : synchronous active-high reset
//   start_stop   : active-low button, each press toggles run/pause
//   hold         : 1 = display tracks live count, 0 = display frozen
//   lap          : active-low button, each press records a lap while running
//   lap_rd       : one-cycle pop strobe for the lap buffer
//   mins/secs/decs          : displayed time
//   overflow     : sticky, count wrapped past MAX_MINS:59:99
//   running      : 1 while counting
//   lap_valid/lap_count/lap_full : lap buffer status
//   lap_mins/lap_secs/lap_decs   : oldest buffered lap
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int MAX_MINS  = 99,
  parameter int LAP_DEPTH = 4
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             start_stop,
  input  logic                             hold,
  input  logic                             lap,
  input  logic                             lap_rd,
  output logic [MINS_W-1:0]                mins,
  output logic [SECS_W-1:0]                secs,
  output logic [DECS_W-1:0]                decs,
  output logic                             overflow,
  output logic                             running,
  output logic                             lap_valid,
  output logic [MINS_W-1:0]                lap_mins,
  output logic [SECS_W-1:0]                lap_secs,
  output logic [DECS_W-1:0]                lap_decs,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_full
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LCNT_W = $clog2(LAP_DEPTH + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [MINS_W-1:0] MAX_M    = MINS_W'(MAX_MINS);

  logic             ss_q;
  logic             running_q, running_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  time_t            live_q, live_d;
  time_t            disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             ss_fall_s, tick_s;

  assign ss_fall_s = ss_q & ~start_stop;
  // Tick depends only on the current running state, so a button edge in
  // the same cycle never swallows it.
  assign tick_s    = running_q & (presc_q == PRE_LAST);

  // Next-state for run flag, prescaler, live count, overflow and display.
  always_comb begin
    running_d = running_q ^ ss_fall_s;
    if (tick_s) begin
      presc_d = '0;
    end else if (running_q) begin
      presc_d = presc_q + PRE_W'(1);
    end else begin
      presc_d = presc_q;  // paused: keep the partial centisecond
    end
    if (tick_s) begin
      live_d = time_next(live_q, MAX_M);
      ovf_d  = ovf_q | time_is_last(live_q, MAX_M);
    end else begin
      live_d = live_q;
      ovf_d  = ovf_q;
    end
    if (hold) begin
      disp_d = live_q;
    end else begin
      disp_d = disp_q;
    end
  end

  // State registers; button registers idle high.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ss_q      <= 1'b1;
      running_q <= 1'b0;
      presc_q   <= '0;
      live_q    <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ss_q      <= start_stop;
      running_q <= running_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mins     = disp_q.mins;
  assign secs     = disp_q.secs;
  assign decs     = disp_q.decs;
  assign overflow = ovf_q;
  assign running  = running_q;

`ifdef STOPWATCH_LAP_EN
  logic              lap_q, lap_fall_s, pop_s, push_s, full_s;
  logic [LCNT_W-1:0] cnt_s;
  time_t             head_s;

  assign lap_fall_s = lap_q & ~lap;
  assign pop_s      = lap_rd & (cnt_s != '0);
  assign push_s     = lap_fall_s & running_q & (~full_s | pop_s);

  // Lap button register, idle high.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lap_q <= 1'b1;
    end else begin
      lap_q <= lap;
    end
  end

  // live_d is pushed so a tick landing in the lap cycle is included.
  lap_fifo #(.DEPTH(LAP_DEPTH)) u_lap_fifo (
    .clk_i   (CLK),
    .rst_i   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (live_d),
    .head_o  (head_s),
    .count_o (cnt_s),
    .full_o  (full_s)
  );

  assign lap_valid = (cnt_s != '0);
  assign lap_count = cnt_s;
  assign lap_full  = full_s;
  assign lap_mins  = head_s.mins;
  assign lap_secs  = head_s.secs;
  assign lap_decs  = head_s.decs;
`else
  logic unused_lap_s;
  assign unused_lap_s = lap ^ lap_rd;

  assign lap_valid = 1'b0;
  assign lap_count = {LCNT_W{1'b0}};
  assign lap_full  = 1'b0;
  assign lap_mins  = 7'd0;
  assign lap_secs  = 6'd0;
  assign lap_decs  = 7'd0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch -- directed self-checking bench for lap_stopwatch.
// Instance A: TICK_DIV=1, MAX_MINS=1, LAP_DEPTH=2 (hold, laps, overflow).
// Instance B: TICK_DIV=4 (prescaler pause/resume).
// Instance F: lap_fifo DEPTH=2 exercised directly.
// Lap-buffer checks follow the STOPWATCH_LAP_EN build setting.
module tb_lap_stopwatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a, ss_a, hold_a, lap_a, rd_a;
  logic [6:0] mins_a, decs_a, lmin_a, ldec_a;
  logic [5:0] secs_a, lsec_a;
  logic       ovf_a, run_a, lv_a, lfull_a;
  logic [1:0] lcnt_a;

  logic       rst_b, ss_b, hold_b, lap_b, rd_b;
  logic [6:0] mins_b, decs_b, lmin_b, ldec_b;
  logic [5:0] secs_b, lsec_b;
  logic       ovf_b, run_b, lv_b, lfull_b;
  logic [2:0] lcnt_b;

  logic        f_rst, f_push, f_pop, f_full;
  logic [19:0] f_data, f_head;
  logic [1:0]  f_cnt;

  lap_stopwatch #(.TICK_DIV(1), .MAX_MINS(1), .LAP_DEPTH(2)) u_a (
    .CLK(clk), .reset(rst_a), .start_stop(ss_a), .hold(hold_a), .lap(lap_a), .lap_rd(rd_a),
    .mins(mins_a), .secs(secs_a), .decs(decs_a), .overflow(ovf_a), .running(run_a),
    .lap_valid(lv_a), .lap_mins(lmin_a), .lap_secs(lsec_a), .lap_decs(ldec_a),
    .lap_count(lcnt_a), .lap_full(lfull_a)
  );

  lap_stopwatch #(.TICK_DIV(4), .MAX_MINS(99), .LAP_DEPTH(4)) u_b (
    .CLK(clk), .reset(rst_b), .start_stop(ss_b), .hold(hold_b), .lap(lap_b), .lap_rd(rd_b),
    .mins(mins_b), .secs(secs_b), .decs(decs_b), .overflow(ovf_b), .running(run_b),
    .lap_valid(lv_b), .lap_mins(lmin_b), .lap_secs(lsec_b), .lap_decs(ldec_b),
    .lap_count(lcnt_b), .lap_full(lfull_b)
  );

  lap_fifo #(.DEPTH(2)) u_f (
    .clk_i(clk), .rst_i(f_rst), .push_i(f_push), .pop_i(f_pop),
    .data_i(f_data), .head_o(f_head), .count_o(f_cnt), .full_o(f_full)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_t(input string tag, input logic [6:0] om, input logic [5:0] os,
                       input logic [6:0] od, input int m, input int s, input int d);
    checks++;
    assert ({om, os, od} === {7'(m), 6'(s), 7'(d)}) else begin
      errors++;
      $error("FAIL %s observed=%0d:%0d:%0d expected=%0d:%0d:%0d", tag, om, os, od, m, s, d);
    end
  endtask

  task automatic start_a();
    ss_a = 1'b0;
    cyc(1);
    ss_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b1; ss_a = 1'b1; hold_a = 1'b1; lap_a = 1'b1; rd_a = 1'b0;
    rst_b = 1'b1; ss_b = 1'b1; hold_b = 1'b1; lap_b = 1'b1; rd_b = 1'b0;
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_data = 20'h0;
    cyc(3);

    // reset state
    chk("rst_running", 32'(run_a), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    chk_t("rst_display", mins_a, secs_a, decs_a, 0, 0, 0);
    chk("rst_lap_count", 32'(lcnt_a), 32'd0);
    chk("rst_running_b", 32'(run_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; f_rst = 1'b0;
    cyc(1);

    // hold: freeze at 0:05:00, release at live 0:08:00
    start_a();
    chk("start_running", 32'(run_a), 32'd1);
    cyc(501);
    chk_t("hold_before", mins_a, secs_a, decs_a, 0, 5, 0);
    hold_a = 1'b0;
    cyc(299);
    chk_t("hold_frozen", mins_a, secs_a, decs_a, 0, 5, 0);
    hold_a = 1'b1;
    cyc(1);
    chk_t("hold_resume", mins_a, secs_a, decs_a, 0, 8, 0);
    // pause on a tick cycle: that tick still lands
    ss_a = 1'b0;
    cyc(1);
    ss_a = 1'b1;
    chk("pause_running", 32'(run_a), 32'd0);
    chk_t("pause_track", mins_a, secs_a, decs_a, 0, 8, 1);
    cyc(3);
    chk_t("pause_tick_kept", mins_a, secs_a, decs_a, 0, 8, 2);

    // prescaler: 10 running cycles, 20 paused, 2 running (+1 for display lag)
    ss_b = 1'b0; cyc(1); ss_b = 1'b1;
    cyc(9);
    ss_b = 1'b0; cyc(1); ss_b = 1'b1;
    chk("b_paused", 32'(run_b), 32'd0);
    chk("b_decs_pause_start", 32'(decs_b), 32'd2);
    cyc(20);
    chk("b_decs_pause_end", 32'(decs_b), 32'd2);
    ss_b = 1'b0; cyc(1); ss_b = 1'b1;
    chk("b_resumed", 32'(run_b), 32'd1);
    cyc(3);
    chk("b_decs_resume", 32'(decs_b), 32'd3);

    // direct FIFO, depth 2
    chk("f_empty_cnt", 32'(f_cnt), 32'd0);
    f_push = 1'b1;
    f_data = 20'h11111; cyc(1);
    f_data = 20'h22222; cyc(1);
    f_data = 20'h33333; cyc(1);
    f_push = 1'b0;
    chk("f_full_cnt", 32'(f_cnt), 32'd2);
    chk("f_full_flag", 32'(f_full), 32'd1);
    chk("f_head1", 32'(f_head), 32'h11111);
    f_push = 1'b1; f_pop = 1'b1; f_data = 20'h44444; cyc(1);
    f_push = 1'b0;
    chk("f_pushpop_cnt", 32'(f_cnt), 32'd2);
    chk("f_head2", 32'(f_head), 32'h22222);
    cyc(1);
    chk("f_head4", 32'(f_head), 32'h44444);
    chk("f_not_full", 32'(f_full), 32'd0);
    cyc(2);
    f_pop = 1'b0;
    chk("f_underflow_cnt", 32'(f_cnt), 32'd0);
    chk("f_empty_head", 32'(f_head), 32'h0);
    f_push = 1'b1; f_data = 20'h55555; cyc(1); f_push = 1'b0;
    chk("f_head5", 32'(f_head), 32'h55555);

    // lap buffer through the top
    rst_a = 1'b1; cyc(1); rst_a = 1'b0; cyc(1);
    start_a();
`ifdef STOPWATCH_LAP_EN
    cyc(9); lap_a = 1'b0; cyc(1); lap_a = 1'b1;
    chk("lap1_count", 32'(lcnt_a), 32'd1);
    chk_t("lap1_head", lmin_a, lsec_a, ldec_a, 0, 0, 10);
    cyc(9); lap_a = 1'b0; cyc(1); lap_a = 1'b1;
    cyc(9); lap_a = 1'b0; cyc(1); lap_a = 1'b1;
    chk("lap3_full", 32'(lfull_a), 32'd1);
    chk("lap3_count", 32'(lcnt_a), 32'd2);
    chk_t("lap3_head", lmin_a, lsec_a, ldec_a, 0, 0, 10);
    rd_a = 1'b1; cyc(1); rd_a = 1'b0;
    chk_t("pop_head", lmin_a, lsec_a, ldec_a, 0, 0, 20);
    chk("pop_count", 32'(lcnt_a), 32'd1);
    cyc(8); lap_a = 1'b0; rd_a = 1'b1; cyc(1); lap_a = 1'b1; rd_a = 1'b0;
    chk("pushpop_count", 32'(lcnt_a), 32'd1);
    chk_t("pushpop_head", lmin_a, lsec_a, ldec_a, 0, 0, 40);
    cyc(9); lap_a = 1'b0; cyc(1); lap_a = 1'b1;
    cyc(9); lap_a = 1'b0; rd_a = 1'b1; cyc(1); lap_a = 1'b1; rd_a = 1'b0;
    chk("pushpop_full_count", 32'(lcnt_a), 32'd2);
    chk_t("pushpop_full_head", lmin_a, lsec_a, ldec_a, 0, 0, 50);
    ss_a = 1'b0; cyc(1); ss_a = 1'b1;
    rd_a = 1'b1; cyc(1); rd_a = 1'b0;
    lap_a = 1'b0; cyc(1); lap_a = 1'b1;
    chk("paused_lap_ignored", 32'(lcnt_a), 32'd1);
    chk_t("paused_head", lmin_a, lsec_a, ldec_a, 0, 0, 60);
    rd_a = 1'b1; cyc(2); rd_a = 1'b0;
    chk("drained_count", 32'(lcnt_a), 32'd0);
    chk("drained_valid", 32'(lv_a), 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      lap_a = 1'b0; cyc(1); lap_a = 1'b1; rd_a = 1'b1; cyc(1); rd_a = 1'b0;
      chk("nolap_valid", 32'(lv_a), 32'd0);
      chk("nolap_count", 32'(lcnt_a), 32'd0);
      chk("nolap_full", 32'(lfull_a), 32'd0);
      chk_t("nolap_head", lmin_a, lsec_a, ldec_a, 0, 0, 0);
    end
`endif

    // 1:00:00 and overflow with MAX_MINS=1
    rst_a = 1'b1; cyc(1); rst_a = 1'b0; cyc(1);
    start_a();
    cyc(6001);
    chk_t("one_minute", mins_a, secs_a, decs_a, 1, 0, 0);
    chk("one_minute_running", 32'(run_a), 32'd1);
    chk("one_minute_ovf", 32'(ovf_a), 32'd0);
    cyc(5999);
    chk_t("last_value", mins_a, secs_a, decs_a, 1, 59, 99);
    cyc(1);
    chk_t("wrap_display", mins_a, secs_a, decs_a, 0, 0, 0);
    chk("wrap_overflow", 32'(ovf_a), 32'd1);
    chk("wrap_running", 32'(run_a), 32'd1);
    cyc(5);
    chk_t("wrap_continues", mins_a, secs_a, decs_a, 0, 0, 5);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    hold_a = 1'b0;
    rst_a = 1'b1; cyc(1);
    chk("reset_ovf", 32'(ovf_a), 32'd0);
    chk("reset_running", 32'(run_a), 32'd0);
    chk_t("reset_display_in_hold", mins_a, secs_a, decs_a, 0, 0, 0);
    rst_a = 1'b0; hold_a = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
